rd_req_sel: RTL and testbench

- N-channel read-request arbiter/multiplexer in front of the DDR3 core wrapper (ddr3_core_alignv).
- Selects one pending channel request and forwards its address and burst length to the core's single read port.
- Routes the core's grant and finish strobes back to the selected channel and fans read data out to all channels.
- Default arbitration is round-robin, so every channel gets service.

---
 rtl/rd_req_sel_pkg.sv | 15 +
 rtl/rd_req_sel_if.sv | 19 +
 rtl/rd_req_sel_rr_arbiter.sv | 27 ++
 rtl/rd_req_sel.sv | 126 ++++++++++++
 tb/tb_rd_req_sel.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rd_req_sel_pkg.sv
// Shared types and constants for the rd_req_sel read-request arbiter.
package rd_req_sel_pkg;
    localparam int RD_NUM_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } rd_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rd_req_sel_if.sv
// Single read port between rd_req_sel (master) and the DDR3 core wrapper (slave).
// Handshake: rd_req is a level held from arbitration until the edge after rd_finish;
// rd_grant marks each valid rd_data beat (may span many cycles); rd_finish is a one-cycle completion pulse.
interface rd_req_sel_if #(
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_ADDR_WIDTH = 28
);
    import rd_req_sel_pkg::*;

    logic                      rd_req;
    logic [APP_ADDR_WIDTH-1:0] rd_addr;
    logic [RD_NUM_W-1:0]       rd_num;
    logic [APP_DATA_WIDTH-1:0] rd_data;
    logic                      rd_grant;
    logic                      rd_finish;

    modport master (output rd_req, rd_addr, rd_num, input rd_data, rd_grant, rd_finish);
    modport slave  (input rd_req, rd_addr, rd_num, output rd_data, rd_grant, rd_finish);
endinterface

// File: rtl/rd_req_sel_rr_arbiter.sv
// Combinational wrap-around search: the first set request at or after ptr wins.
module rr_arbiter
    import rd_req_sel_pkg::*;
#(
    parameter  int CHANNEL_NUM = 2,
    localparam int IDX_W       = idx_w(CHANNEL_NUM)
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [IDX_W-1:0]       win_idx,
    output logic                   win_valid
);
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        // Walk from farthest to nearest so the closest requester overwrites earlier hits.
        for (int k = CHANNEL_NUM - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= CHANNEL_NUM) j = j - CHANNEL_NUM;
            if (req[j]) begin
                win_idx   = IDX_W'(j);
                win_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rd_req_sel.sv
// N-channel read-request arbiter/mux in front of the DDR3 core read port.
// Define RD_REQ_SEL_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rd_req_sel
    import rd_req_sel_pkg::*;
#(
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_ADDR_WIDTH = 28,
    parameter int CHANNEL_NUM    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CHANNEL_NUM-1:0]             rd_req_,
    input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] rd_addr_,
    input  logic [RD_NUM_W*CHANNEL_NUM-1:0]    rd_num_,
    output logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] rd_data_,
    output logic [CHANNEL_NUM-1:0]             rd_grant_,
    output logic [CHANNEL_NUM-1:0]             rd_finish_,
    rd_req_sel_if.master                       core,
    output rd_state_e                          dbg_state
);
    localparam int IDX_W = idx_w(CHANNEL_NUM);

    rd_state_e                 state_q, state_d;
    logic [IDX_W-1:0]          sel_q, sel_d;
    logic                      req_q, req_d;
    logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RD_NUM_W-1:0]       num_q, num_d;
    logic                      done;
    logic [IDX_W-1:0]          arb_ptr;
    logic [IDX_W-1:0]          win_idx;
    logic                      win_valid;

    logic [APP_ADDR_WIDTH-1:0] addr_arr [CHANNEL_NUM];
    logic [RD_NUM_W-1:0]       num_arr  [CHANNEL_NUM];

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_slice
        assign addr_arr[i] = rd_addr_[i*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
        assign num_arr[i]  = rd_num_[i*RD_NUM_W +: RD_NUM_W];
    end

    rr_arbiter #(.CHANNEL_NUM(CHANNEL_NUM)) u_arb (
        .req       (rd_req_),
        .ptr       (arb_ptr),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

`ifdef RD_REQ_SEL_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (done) begin
            ptr_q <= (sel_q == IDX_W'(CHANNEL_NUM - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    assign arb_ptr = ptr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        addr_d  = addr_q;
        num_d   = num_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    sel_d   = win_idx;
                    addr_d  = addr_arr[win_idx];
                    num_d   = num_arr[win_idx];
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A finish alongside the first grant still completes the transaction.
                if (core.rd_finish)     done    = 1'b1;
                else if (core.rd_grant) state_d = BUSY;
            end
            BUSY:    if (core.rd_finish) done = 1'b1;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done) begin
            req_d   = 1'b0;
            state_d = GAP;
        end
    end

    always_comb begin
        rd_grant_  = '0;
        rd_finish_ = '0;
        if (state_q == REQ || state_q == BUSY) begin
            rd_grant_[sel_q]  = core.rd_grant;
            rd_finish_[sel_q] = core.rd_finish;
        end
    end

    assign rd_data_     = {CHANNEL_NUM{core.rd_data}};
    assign core.rd_req  = req_q;
    assign core.rd_addr = addr_q;
    assign core.rd_num  = num_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_rd_req_sel.sv
// Self-checking bench for rd_req_sel: a core model serves requests and a scoreboard checks each selection.
module tb_rd_req_sel;
    import rd_req_sel_pkg::*;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int N  = 2;
    localparam int EW = 8 + AW + RD_NUM_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         rd_req_;
    logic [AW*N-1:0]      rd_addr_;
    logic [RD_NUM_W*N-1:0] rd_num_;
    logic [DW*N-1:0]      rd_data_;
    logic [N-1:0]         rd_grant_;
    logic [N-1:0]         rd_finish_;
    rd_state_e            dbg_state;

    rd_req_sel_if #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW)) bus ();

    rd_req_sel #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .CHANNEL_NUM(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req_    (rd_req_),
        .rd_addr_   (rd_addr_),
        .rd_num_    (rd_num_),
        .rd_data_   (rd_data_),
        .rd_grant_  (rd_grant_),
        .rd_finish_ (rd_finish_),
        .core       (bus),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];
    int served[N];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [RD_NUM_W-1:0] n);
        rd_addr_[ch*AW +: AW]             = a;
        rd_num_[ch*RD_NUM_W +: RD_NUM_W]  = n;
    endtask

    task automatic push_exp(input int ch, input logic [AW-1:0] a, input logic [RD_NUM_W-1:0] n);
        exp_q.push_back({8'(ch), a, n});
    endtask

    // Core model: waits for rd_req, checks it against the scoreboard, then grants/finishes.
    task automatic core_serve(input int glen, input bit same, input bit drop, input bit disturb);
        int waited;
        int ch;
        bit data_ok;
        logic [EW-1:0]       e;
        logic [AW-1:0]       ea;
        logic [RD_NUM_W-1:0] en;
        logic [N-1:0]        oh;
        logic [DW-1:0]       d;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.rd_req !== 1'b1 && waited < 50);
        n_checks++;
        if (waited != 1) begin
            n_errors++;
            $display("FAIL req_latency: got %0d clk, expected 1 clk", waited);
        end
        if (bus.rd_req !== 1'b1) return;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_empty: got request with empty scoreboard, expected none");
            return;
        end
        e  = exp_q.pop_front();
        ch = int'(e[EW-1 -: 8]);
        ea = e[RD_NUM_W +: AW];
        en = e[RD_NUM_W-1:0];
        oh = N'(1) << ch;
        n_checks++;
        if (bus.rd_addr !== ea) begin
            n_errors++;
            $display("FAIL rd_addr: got %0h expected %0h (ch %0d)", bus.rd_addr, ea, ch);
        end
        n_checks++;
        if (bus.rd_num !== en) begin
            n_errors++;
            $display("FAIL rd_num: got %0d expected %0d (ch %0d)", bus.rd_num, en, ch);
        end
        if (disturb) begin
            set_ch(ch, ~ea, ~en);
            rd_req_[ch] = 1'b0;
        end
        for (int g = 0; g < glen; g++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            bus.rd_data  = d;
            bus.rd_grant = 1'b1;
            #1;
            n_checks++;
            if (rd_grant_ !== oh) begin
                n_errors++;
                $display("FAIL grant_route: got %b expected %b", rd_grant_, oh);
            end
            n_checks++;
            if (rd_finish_ !== '0) begin
                n_errors++;
                $display("FAIL finish_early: got %b expected 0", rd_finish_);
            end
            data_ok = 1'b1;
            for (int i = 0; i < N; i++) if (rd_data_[i*DW +: DW] !== d) data_ok = 1'b0;
            n_checks++;
            if (!data_ok) begin
                n_errors++;
                $display("FAIL data_fanout: got %0h expected %0h replicated", rd_data_, d);
            end
            n_checks++;
            if (bus.rd_addr !== ea || bus.rd_num !== en) begin
                n_errors++;
                $display("FAIL addr_frozen: got %0h/%0d expected %0h/%0d", bus.rd_addr, bus.rd_num, ea, en);
            end
            @(negedge clk);
        end
        bus.rd_grant  = same;
        bus.rd_finish = 1'b1;
        #1;
        n_checks++;
        if (rd_finish_ !== oh) begin
            n_errors++;
            $display("FAIL finish_route: got %b expected %b", rd_finish_, oh);
        end
        n_checks++;
        if (rd_grant_ !== (same ? oh : N'(0))) begin
            n_errors++;
            $display("FAIL grant_at_finish: got %b expected %b", rd_grant_, same ? oh : N'(0));
        end
        n_checks++;
        if (bus.rd_req !== 1'b1) begin
            n_errors++;
            $display("FAIL req_hold: got %b expected 1", bus.rd_req);
        end
        served[ch]++;
        @(negedge clk);
        bus.rd_grant  = 1'b0;
        bus.rd_finish = 1'b0;
        if (drop) rd_req_[ch] = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_req !== 1'b0 || rd_finish_ !== '0) begin
            n_errors++;
            $display("FAIL gap1: got req=%b finish_=%b expected 0/0", bus.rd_req, rd_finish_);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rd_req !== 1'b0) begin
            n_errors++;
            $display("FAIL gap2: got req=%b expected 0", bus.rd_req);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rd_req_ = '1;
        rd_addr_ = '1;
        rd_num_ = '1;
        bus.rd_data = '0;
        bus.rd_grant = 1'b1;
        bus.rd_finish = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.rd_req !== 1'b0 || bus.rd_addr !== '0 || bus.rd_num !== '0) begin
            n_errors++;
            $display("FAIL reset_regs: got req=%b addr=%0h num=%0d expected 0/0/0", bus.rd_req, bus.rd_addr, bus.rd_num);
        end
        n_checks++;
        if (rd_grant_ !== '0 || rd_finish_ !== '0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b/%b expected 0/0", rd_grant_, rd_finish_);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        rd_req_ = '0;
        bus.rd_grant = 1'b0;
        bus.rd_finish = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_ch(0, 28'h02, 10'd86);
        push_exp(0, 28'h02, 10'd86);
        rd_req_[0] = 1'b1;
        core_serve(2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_both();
        apply_reset();
        set_ch(0, 28'h02, 10'd86);
        set_ch(1, 28'h01, 10'd96);
        push_exp(0, 28'h02, 10'd86);
        push_exp(1, 28'h01, 10'd96);
        rd_req_ = 2'b11;
        core_serve(1, 1'b0, 1'b1, 1'b0);
        core_serve(3, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_same_cycle();
        set_ch(1, 28'h05, 10'd0);
        push_exp(1, 28'h05, 10'd0);
        rd_req_[1] = 1'b1;
        core_serve(0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_drop_midway();
        set_ch(0, 28'h123, 10'd7);
        push_exp(0, 28'h123, 10'd7);
        rd_req_[0] = 1'b1;
        core_serve(2, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_busy();
        int waited;
        set_ch(1, 28'h77, 10'd12);
        rd_req_[1] = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.rd_req !== 1'b1 && waited < 50);
        n_checks++;
        if (bus.rd_req !== 1'b1 || bus.rd_addr !== 28'h77) begin
            n_errors++;
            $display("FAIL rb_req: got req=%b addr=%0h expected 1/77", bus.rd_req, bus.rd_addr);
        end
        bus.rd_grant = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== BUSY) begin
            n_errors++;
            $display("FAIL rb_busy: got state %0d expected %0d", dbg_state, BUSY);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_req !== 1'b0 || rd_grant_ !== '0 || dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL rb_async: got req=%b grant_=%b state=%0d expected 0/00/0", bus.rd_req, rd_grant_, dbg_state);
        end
        repeat (2) @(negedge clk);
        bus.rd_grant = 1'b0;
        set_ch(1, 28'h88, 10'd20);
        push_exp(1, 28'h88, 10'd20);
        rst_n = 1'b1;
        core_serve(1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int base[N];
        int exp_cnt[N];
        int exp_ch;
        logic [AW-1:0]       a;
        logic [RD_NUM_W-1:0] n;
        for (int i = 0; i < N; i++) begin
            base[i] = served[i];
            exp_cnt[i] = 0;
        end
        rd_req_ = '1;
        for (int t = 0; t < 1000; t++) begin
`ifdef RD_REQ_SEL_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = t % N;
`endif
            for (int i = 0; i < N; i++) begin
                a = AW'($urandom);
                n = RD_NUM_W'($urandom_range(0, 1023));
                set_ch(i, a, n);
                if (i == exp_ch) push_exp(i, a, n);
            end
            exp_cnt[exp_ch]++;
            core_serve($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        rd_req_ = '0;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (served[i] - base[i] != exp_cnt[i]) begin
                n_errors++;
                $display("FAIL rr_count ch%0d: got %0d expected %0d", i, served[i] - base[i], exp_cnt[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < N; i++) served[i] = 0;
        test_reset();
        test_single();
        test_both();
        test_same_cycle();
        test_drop_midway();
        test_reset_busy();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
